id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
- Directly upstream of the ALU: drives Operand1, Operand2 and Control from decoded instruction fields.
- Resolves RAW hazards against the EX/MEM and MEM/WB stages.
- Raises a load-use stall to the IF/ID logic and inserts a bubble.

Parameters:
- XLEN, 32, datapath width
- CTRL_W, 4, ALU control width (same encoding as the ALU: 0000 ADD … 1111 MOD)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- IdValid  in  1  ID holds a real instruction
- IdRs1Addr, IdRs2Addr, IdRdAddr  in  5 each  register indices
- IdUsesRs2  in  1  instruction reads rs2 (R-type/store/branch)
- IdRs1Data, IdRs2Data  in  XLEN each  register-file read data
- IdImm  in  XLEN  sign-extended immediate
- IdAluControl  in  CTRL_W  ALU operation
- IdAluSrc  in  1  1 = Operand2 takes immediate
- IdRegWrite, IdMemRead, IdMemWrite  in  1 each  control bits
- Flush  in  1  kill the instruction entering EX (branch taken)
- Hold  in  1  downstream stall; freeze ID/EX contents
- ExMemRegWrite  in  1; ExMemRdAddr  in  5; ExMemResult  in  XLEN  forwarding source 1
- MemWbRegWrite  in  1; MemWbRdAddr  in  5; MemWbResult  in  XLEN  forwarding source 2
- Operand1, Operand2  out  XLEN each  to ALU
- Control  out  CTRL_W  to ALU
- ExStoreData  out  XLEN  forwarded rs2 for stores
- ExRdAddr  out  5
- ExValid, ExRegWrite, ExMemRead, ExMemWrite  out  1 each
- LoadUseStall  out  1  to PC/IF-ID: hold fetch and decode this cycle

Behaviour:
- Registered fields: valid, rs1/rs2/rd addresses, rs1/rs2 data, imm, control, AluSrc, RegWrite, MemRead, MemWrite.
- Reset clears every registered field to 0. After reset: ExValid=0, all control outputs 0, Control=0000, Operand1=Operand2=ExStoreData=0, LoadUseStall=0.
- Per-edge priority: Reset > Flush > Hold > LoadUseStall > normal load.
  - Flush: load bubble.
  - Hold: retain all registers.
  - LoadUseStall: load bubble.
  - Normal: capture all Id* inputs, with ExValid <= IdValid.
- Bubble: valid, RegWrite, MemRead, MemWrite and rd cleared to 0. Data fields are don't-care but are driven to 0.
- LoadUseStall (combinational) = ExValid & ExMemRead & (ExRdAddr≠0) & IdValid & ((IdRs1Addr==ExRdAddr) | (IdUsesRs2 & IdRs2Addr==ExRdAddr)).
  - Forced to 0 when Flush or Hold is active, because the upstream holds anyway.
  - The upstream holds ID while LoadUseStall=1. Latency: exactly one bubble per load-use pair.
- Forwarding (combinational from registered state), for each source operand s ∈ {rs1, rs2}:
  - If ExMemRegWrite & ExMemRdAddr≠0 & ExMemRdAddr==s_addr: use ExMemResult.
  - Else if MemWbRegWrite & MemWbRdAddr≠0 & MemWbRdAddr==s_addr: use MemWbResult.
  - Else: use the registered register-file data.
  - EX/MEM always wins over MEM/WB. x0 is never forwarded, so it reads as the registered data (0).
- Operand1 = fwd_rs1.
- Operand2 = AluSrc ? imm : fwd_rs2.
- ExStoreData = fwd_rs2, independent of AluSrc.
- Control = registered IdAluControl. Bubbles carry Control=0000.
- Operand outputs are valid the cycle after capture. No arithmetic is performed in this block; widths are pass-through XLEN.
- Reset asserted mid-stall clears the stall state immediately at the next edge. No residual bubble or stall persists.

Test Plan:
1. Reset held 2 cycles with IdValid=1 and random inputs -> ExValid=0, Operand1=Operand2=0, Control=0000, LoadUseStall=0.
2. Load ADD IdRs1Data=5, IdRs2Data=7, Control=0000, no forward matches -> next cycle Operand1=5, Operand2=7, ExValid=1. Repeat with IdAluSrc=1, IdImm=0xFFFFFFF0 -> Operand2=0xFFFFFFF0.
3. EX has rs1=3. ExMemRdAddr=3 with ExMemResult=0x11, and MemWbRdAddr=3 with MemWbResult=0x22, both RegWrite=1 -> Operand1=0x11. With ExMemRegWrite=0 -> 0x22. With rs1=0 and both sources targeting rd 0 -> Operand1=registered data.
4. EX holds a load with rd=4, ID is an ADD with rs2=4 and IdUsesRs2=1 -> LoadUseStall=1 for one cycle, then ExValid=0 and RegWrite=0. On the following cycle the ADD enters, and MemWbResult=0x99 for rd 4 forwards to Operand2=0x99. With IdUsesRs2=0 -> no stall.
5. Hold=1 for 3 cycles while Id* inputs change -> all outputs frozen. Hold=1 and Flush=1 together -> bubble. Flush during a load-use condition -> bubble and LoadUseStall=0.
6. Store with IdAluSrc=1 and rs2 matching ExMemRdAddr (ExMemResult=0xABCD) -> Operand2=imm, ExStoreData=0xABCD, ExMemWrite=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX operand forwarding and load-use stall
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IdValid,
  input  logic [4:0]        IdRs1Addr,
  input  logic [4:0]        IdRs2Addr,
  input  logic [4:0]        IdRdAddr,
  input  logic              IdUsesRs2,
  input  logic [XLEN-1:0]   IdRs1Data,
  input  logic [XLEN-1:0]   IdRs2Data,
  input  logic [XLEN-1:0]   IdImm,
  input  logic [CTRL_W-1:0] IdAluControl,
  input  logic              IdAluSrc,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  input  logic              IdMemWrite,
  input  logic              Flush,
  input  logic              Hold,
  input  logic              ExMemRegWrite,
  input  logic [4:0]        ExMemRdAddr,
  input  logic [XLEN-1:0]   ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [4:0]        MemWbRdAddr,
  input  logic [XLEN-1:0]   MemWbResult,
  output logic [XLEN-1:0]   Operand1,
  output logic [XLEN-1:0]   Operand2,
  output logic [CTRL_W-1:0] Control,
  output logic [XLEN-1:0]   ExStoreData,
  output logic [4:0]        ExRdAddr,
  output logic              ExValid,
  output logic              ExRegWrite,
  output logic              ExMemRead,
  output logic              ExMemWrite,
  output logic              LoadUseStall
);

  logic              valid_q;
  logic [4:0]        rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              alu_src_q, reg_write_q, mem_read_q, mem_write_q;
  logic              load_use;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

  // Flush/Hold already freeze or kill the upstream, so the stall is suppressed then.
  always_comb begin
    load_use = valid_q & mem_read_q & (rd_addr_q != 5'd0) & IdValid &
               ((IdRs1Addr == rd_addr_q) | (IdUsesRs2 & (IdRs2Addr == rd_addr_q))) &
               ~Flush & ~Hold;
  end

  always_ff @(posedge Clock) begin
    if (Reset || Flush || (!Hold && load_use)) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!Hold) begin
      valid_q     <= IdValid;
      rs1_addr_q  <= IdRs1Addr;
      rs2_addr_q  <= IdRs2Addr;
      rd_addr_q   <= IdRdAddr;
      rs1_data_q  <= IdRs1Data;
      rs2_data_q  <= IdRs2Data;
      imm_q       <= IdImm;
      ctrl_q      <= IdAluControl;
      alu_src_q   <= IdAluSrc;
      reg_write_q <= IdRegWrite;
      mem_read_q  <= IdMemRead;
      mem_write_q <= IdMemWrite;
    end
  end

  // EX/MEM is the younger producer, so it takes precedence; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (ExMemRegWrite && (ExMemRdAddr != 5'd0) && (ExMemRdAddr == rs1_addr_q))
      fwd_rs1 = ExMemResult;
    else if (MemWbRegWrite && (MemWbRdAddr != 5'd0) && (MemWbRdAddr == rs1_addr_q))
      fwd_rs1 = MemWbResult;
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (ExMemRegWrite && (ExMemRdAddr != 5'd0) && (ExMemRdAddr == rs2_addr_q))
      fwd_rs2 = ExMemResult;
    else if (MemWbRegWrite && (MemWbRdAddr != 5'd0) && (MemWbRdAddr == rs2_addr_q))
      fwd_rs2 = MemWbResult;
  end

  assign Operand1     = fwd_rs1;
  assign Operand2     = alu_src_q ? imm_q : fwd_rs2;
  assign ExStoreData  = fwd_rs2;
  assign Control      = ctrl_q;
  assign ExRdAddr     = rd_addr_q;
  assign ExValid      = valid_q;
  assign ExRegWrite   = reg_write_q;
  assign ExMemRead    = mem_read_q;
  assign ExMemWrite   = mem_write_q;
  assign LoadUseStall = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IdValid, IdUsesRs2, IdAluSrc, IdRegWrite, IdMemRead, IdMemWrite;
  logic [4:0]  IdRs1Addr, IdRs2Addr, IdRdAddr;
  logic [31:0] IdRs1Data, IdRs2Data, IdImm;
  logic [3:0]  IdAluControl;
  logic        Flush, Hold;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemRdAddr, MemWbRdAddr;
  logic [31:0] ExMemResult, MemWbResult;
  logic [31:0] Operand1, Operand2, ExStoreData;
  logic [3:0]  Control;
  logic [4:0]  ExRdAddr;
  logic        ExValid, ExRegWrite, ExMemRead, ExMemWrite, LoadUseStall;

  id_ex_stage #(.XLEN(32), .CTRL_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .IdValid(IdValid),
    .IdRs1Addr(IdRs1Addr), .IdRs2Addr(IdRs2Addr), .IdRdAddr(IdRdAddr),
    .IdUsesRs2(IdUsesRs2), .IdRs1Data(IdRs1Data), .IdRs2Data(IdRs2Data),
    .IdImm(IdImm), .IdAluControl(IdAluControl), .IdAluSrc(IdAluSrc),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
    .Flush(Flush), .Hold(Hold),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRdAddr(ExMemRdAddr), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRdAddr(MemWbRdAddr), .MemWbResult(MemWbResult),
    .Operand1(Operand1), .Operand2(Operand2), .Control(Control),
    .ExStoreData(ExStoreData), .ExRdAddr(ExRdAddr), .ExValid(ExValid),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .LoadUseStall(LoadUseStall)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int           cyc;
    string        name;
    logic [109:0] vec;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge Clock) cycle <= cycle + 1;

  function automatic logic [109:0] pack(input logic v, rw, mr, mw, lus,
                                        input logic [4:0] rd, input logic [3:0] c,
                                        input logic [31:0] op1, op2, sd);
    return {v, rw, mr, mw, lus, rd, c, op1, op2, sd};
  endfunction

  function automatic string fmt(input logic [109:0] x);
    return $sformatf("v=%b rw=%b mr=%b mw=%b lus=%b rd=%0d ctl=%h op1=%h op2=%h sd=%h",
                     x[109], x[108], x[107], x[106], x[105], x[104:100], x[99:96],
                     x[95:64], x[63:32], x[31:0]);
  endfunction

  task automatic expect_out(input string name, input logic v, rw, mr, mw, lus,
                            input logic [4:0] rd, input logic [3:0] c,
                            input logic [31:0] op1, op2, sd);
    exp_t e;
    e.cyc  = cycle;
    e.name = name;
    e.vec  = pack(v, rw, mr, mw, lus, rd, c, op1, op2, sd);
    sb.push_back(e);
  endtask

  task automatic expect_bubble(input string name);
    expect_out(name, 0, 0, 0, 0, 0, 5'd0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: outputs settle mid-cycle; compare every entry due this cycle.
  always @(negedge Clock) begin
    logic [109:0] act;
    exp_t         e;
    act = pack(ExValid, ExRegWrite, ExMemRead, ExMemWrite, LoadUseStall,
               ExRdAddr, Control, Operand1, Operand2, ExStoreData);
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cycle) begin
        n_bad++;
        $display("FAIL %s: sample missed (due cycle %0d, now %0d)", e.name, e.cyc, cycle);
      end else if (act !== e.vec) begin
        n_bad++;
        $display("FAIL %s: got %s required %s", e.name, fmt(act), fmt(e.vec));
      end
    end
  end

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, rs2, rd, input logic u2,
                        input logic [31:0] d1, d2, im, input logic [3:0] c,
                        input logic src, rw, mr, mw);
    IdValid = v; IdRs1Addr = rs1; IdRs2Addr = rs2; IdRdAddr = rd; IdUsesRs2 = u2;
    IdRs1Data = d1; IdRs2Data = d2; IdImm = im; IdAluControl = c;
    IdAluSrc = src; IdRegWrite = rw; IdMemRead = mr; IdMemWrite = mw;
  endtask

  task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
    ExMemRegWrite = erw; ExMemRdAddr = erd; ExMemResult = eres;
    MemWbRegWrite = mrw; MemWbRdAddr = mrd; MemWbResult = mres;
  endtask

  task automatic set_lw();
    set_id(1, 5'd1, 5'd0, 5'd4, 0, 32'h100, 32'h0, 32'h8, 4'h0, 1, 1, 1, 0);
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; Hold = 1'b0;
    set_id(1, 5'($urandom), 5'($urandom), 5'($urandom), 1, $urandom, $urandom, $urandom,
           4'($urandom), 1'($urandom), 1, 1, 1);
    set_fwd(1, 5'($urandom), $urandom, 1, 5'($urandom), $urandom);
    next_cycle();
    next_cycle();
    expect_bubble("reset_state");
    Reset = 1'b0;
    set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 32'd5, 32'd7, 32'h0, 4'h0, 0, 1, 0, 0);
    next_cycle();

    expect_out("add_regs", 1, 1, 0, 0, 0, 5'd5, 4'h0, 32'd5, 32'd7, 32'd7);
    set_id(1, 5'd1, 5'd2, 5'd6, 0, 32'd5, 32'd7, 32'hFFFFFFF0, 4'h0, 1, 1, 0, 0);
    next_cycle();

    expect_out("addi_imm", 1, 1, 0, 0, 0, 5'd6, 4'h0, 32'd5, 32'hFFFFFFF0, 32'd7);
    set_id(1, 5'd3, 5'd0, 5'd7, 1, 32'h33, 32'h0, 32'h0, 4'h2, 0, 1, 0, 0);
    next_cycle();

    set_fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    Hold = 1'b1;
    set_id(0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0);
    expect_out("fwd_exmem_wins", 1, 1, 0, 0, 0, 5'd7, 4'h2, 32'h11, 32'h0, 32'h0);
    next_cycle();

    set_fwd(0, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    Hold = 1'b0;
    set_id(1, 5'd0, 5'd0, 5'd8, 1, 32'h5A, 32'h6B, 32'h0, 4'h3, 0, 1, 0, 0);
    expect_out("fwd_memwb", 1, 1, 0, 0, 0, 5'd7, 4'h2, 32'h22, 32'h0, 32'h0);
    next_cycle();

    set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    set_lw();
    expect_out("x0_no_fwd", 1, 1, 0, 0, 0, 5'd8, 4'h3, 32'h5A, 32'h6B, 32'h6B);
    next_cycle();

    set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    set_id(1, 5'd5, 5'd4, 5'd9, 1, 32'h10, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0);
    expect_out("load_use_stall", 1, 1, 1, 0, 1, 5'd4, 4'h0, 32'h100, 32'h8, 32'h0);
    next_cycle();

    expect_bubble("stall_bubble");
    next_cycle();

    set_fwd(0, 5'd0, 32'h0, 1, 5'd4, 32'h99);
    set_lw();
    expect_out("fwd_after_bubble", 1, 1, 0, 0, 0, 5'd9, 4'h0, 32'h10, 32'h99, 32'h99);
    next_cycle();

    set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    set_id(1, 5'd5, 5'd4, 5'd9, 0, 32'h10, 32'h44, 32'h0, 4'h0, 0, 1, 0, 0);
    expect_out("no_stall_rs2_unused", 1, 1, 1, 0, 0, 5'd4, 4'h0, 32'h100, 32'h8, 32'h0);
    next_cycle();

    Hold = 1'b1;
    set_id(1, 5'd6, 5'd7, 5'd10, 1, 32'hAAA, 32'hBBB, 32'h0, 4'h1, 0, 1, 0, 0);
    expect_out("add_enters", 1, 1, 0, 0, 0, 5'd9, 4'h0, 32'h10, 32'h44, 32'h44);
    next_cycle();

    for (int i = 0; i < 3; i++) begin
      if (i == 2) Flush = 1'b1;
      set_id(1, 5'(7 + i), 5'(8 + i), 5'(11 + i), 1, 32'(i * 3 + 1), 32'(i * 5 + 2),
             32'(i), 4'(i + 5), 1'(i), 1, 1'(i), 0);
      expect_out($sformatf("hold_frozen_%0d", i), 1, 1, 0, 0, 0, 5'd9, 4'h0,
                 32'h10, 32'h44, 32'h44);
      next_cycle();
    end

    Hold = 1'b0;
    Flush = 1'b0;
    set_lw();
    expect_bubble("hold_flush_bubble");
    next_cycle();

    Flush = 1'b1;
    set_id(1, 5'd4, 5'd0, 5'd9, 0, 32'h10, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0);
    expect_out("flush_masks_stall", 1, 1, 1, 0, 0, 5'd4, 4'h0, 32'h100, 32'h8, 32'h0);
    next_cycle();

    Flush = 1'b0;
    set_id(1, 5'd2, 5'd3, 5'd0, 1, 32'h200, 32'h1, 32'h10, 4'h0, 1, 0, 0, 1);
    expect_bubble("flush_bubble");
    next_cycle();

    set_fwd(1, 5'd3, 32'hABCD, 0, 5'd0, 32'h0);
    set_lw();
    expect_out("store_fwd", 1, 0, 0, 1, 0, 5'd0, 4'h0, 32'h200, 32'h10, 32'hABCD);
    next_cycle();

    set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    set_id(1, 5'd4, 5'd0, 5'd9, 0, 32'h10, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0);
    Reset = 1'b1;
    expect_out("stall_before_reset", 1, 1, 1, 0, 1, 5'd4, 4'h0, 32'h100, 32'h8, 32'h0);
    next_cycle();

    Reset = 1'b0;
    expect_bubble("reset_mid_stall");
    next_cycle();

    set_id(0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0);
    expect_out("after_reset_no_stall", 1, 1, 0, 0, 0, 5'd9, 4'h0, 32'h10, 32'h0, 32'h0);
    next_cycle();

    repeat (2) @(posedge Clock);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
